// File: rtl/ss_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ss_pkg
//  Description : Shared constants, state encoding and slot-select helper for
//                the byte-stream adapter around the 8-input parallel sorter.
//  Revision    : 1.0 - initial release
// ============================================================================
package ss_pkg;

    // Frame geometry and sorter pipeline depth
    localparam int N        = 8;
    localparam int W        = 8;
    localparam int SORT_LAT = 2;

    // Counter widths: indices never wrap past N-1, wait counter holds 0..SORT_LAT
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(SORT_LAT + 1);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] c_LAT_LOAD = CNT_W'(SORT_LAT);

    // Adapter state encoding
    localparam logic [1:0] c_FILL  = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    // Pick element idx out of a packed N*W vector (slot k at bits [k*W +: W])
    function automatic logic [W-1:0] slot_sel(input logic [N*W-1:0] vec,
                                               input logic [IDX_W-1:0] idx);
        return vec[idx*W +: W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ss_frame_ser.sv
`default_nettype none
// ============================================================================
//  Module      : ss_frame_ser
//  Description : Holds one captured sorted frame and serialises it on the
//                m_* valid/ready interface, smallest element first.
//  Revision    : 1.0 - initial release
// ============================================================================
module ss_frame_ser
    import ss_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           capture,
    input  logic [N*W-1:0] sort_out,
    output logic           m_valid,
    output logic [W-1:0]   m_data,
    output logic           m_last,
    input  logic           m_ready,
    output logic           done
);

    logic [N*W-1:0]   r_buf;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid;
    logic             w_hs;

    // A handshake racing a flush is dropped: flush wins
    assign w_hs = r_valid && m_ready && !flush;
    assign done = w_hs && (r_idx == c_LAST_IDX);

    // Capture buffer, drain index and output-valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (capture) begin
            r_buf   <= sort_out;
            r_idx   <= '0;
            r_valid <= 1'b1;
        end else if (w_hs) begin
            if (r_idx == c_LAST_IDX) begin
                r_idx   <= '0;
                r_valid <= 1'b0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    // Outputs decode only registered state, so m_ready never reaches them
    assign m_valid = r_valid;
    assign m_data  = slot_sel(r_buf, r_idx);
    assign m_last  = r_valid && (r_idx == c_LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/ss_stream_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : ss_stream_adapter
//  Description : Collects N serial bytes into a frame for the parallel sorter,
//                waits out the sorter latency, captures the sorted vector and
//                streams it back out with a last flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module ss_stream_adapter
    import ss_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           s_valid,
    input  logic [W-1:0]   s_data,
    output logic           s_ready,
    output logic           m_valid,
    output logic [W-1:0]   m_data,
    output logic           m_last,
    input  logic           m_ready,
    output logic [N*W-1:0] sort_in,
    input  logic [N*W-1:0] sort_out,
    output logic           busy
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [IDX_W-1:0] r_fill_idx;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [N*W-1:0]   r_sort_in;
    logic             w_accept;
    logic             w_frame_full;
    logic             w_capture;
    logic             w_drain_done;

    assign w_accept     = s_valid && s_ready && !flush;
    assign w_frame_full = w_accept && (r_fill_idx == c_LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; flush forces FILL from anywhere
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = c_FILL;
        end else begin
            case (r_state)
                c_FILL:  if (w_frame_full)       w_state_nxt = c_WAIT;
                c_WAIT:  if (r_wait_cnt == '0)   w_state_nxt = c_DRAIN;
                c_DRAIN: if (w_drain_done)       w_state_nxt = c_FILL;
                default:                         w_state_nxt = c_FILL;
            endcase
        end
    end

    // State-derived outputs and strobes
    always_comb begin
        s_ready   = (r_state == c_FILL);
        busy      = (r_state != c_FILL) || (r_fill_idx != '0);
        w_capture = (r_state == c_WAIT) && (r_wait_cnt == '0) && !flush;
    end

    // Fill index: one step per accepted byte, back to 0 after the last slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_idx <= '0;
        end else if (flush) begin
            r_fill_idx <= '0;
        end else if (w_accept) begin
            r_fill_idx <= (r_fill_idx == c_LAST_IDX) ? '0 : r_fill_idx + IDX_W'(1);
        end
    end

    // Latency counter: loaded on the final accept, counts down through WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (flush) begin
            r_wait_cnt <= '0;
        end else if (w_frame_full) begin
            r_wait_cnt <= c_LAT_LOAD;
        end else if ((r_state == c_WAIT) && (r_wait_cnt != '0)) begin
            r_wait_cnt <= r_wait_cnt - CNT_W'(1);
        end
    end

    // Sorter input slots; old frame is kept until overwritten slot by slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sort_in <= '0;
        end else if (w_accept) begin
            r_sort_in[r_fill_idx*W +: W] <= s_data;
        end
    end

    assign sort_in = r_sort_in;

    ss_frame_ser u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .capture  (w_capture),
        .sort_out (sort_out),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .done     (w_drain_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_ss_stream_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ss_stream_adapter
//  Description : Self-checking bench for ss_stream_adapter with a two-stage
//                registered sorter model attached to sort_in/sort_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ss_stream_adapter;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        flush   = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data  = 8'h00;
    logic        s_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_ready = 1'b1;
    logic [63:0] sort_in;
    logic [63:0] sort_out;
    logic        busy;

    always #5 clk = ~clk;

    ss_stream_adapter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .sort_in  (sort_in),
        .sort_out (sort_out),
        .busy     (busy)
    );

    // Ascending sort of eight unsigned bytes, slot 0 smallest
    function automatic logic [63:0] sort8(input logic [63:0] v);
        logic [7:0]  a [8];
        logic [7:0]  t;
        logic [63:0] r;
        for (int i = 0; i < 8; i++) a[i] = v[i*8 +: 8];
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = a[i];
        return r;
    endfunction

    function automatic logic [63:0] mk(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3,
                                       input logic [7:0] b4, input logic [7:0] b5,
                                       input logic [7:0] b6, input logic [7:0] b7);
        return {b7, b6, b5, b4, b3, b2, b1, b0};
    endfunction

    // Sorter model: input register stage, then sorted output register stage
    logic [63:0] srt_in_r  = 64'h0;
    logic [63:0] srt_out_r = 64'h0;
    always @(posedge clk) begin
        srt_in_r  <= sort_in;
        srt_out_r <= sort8(srt_in_r);
    end
    assign sort_out = srt_out_r;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard of expected output beats {last, data}
    logic [8:0] exp_q [$];

    task automatic push_frame(input logic [63:0] sorted);
        for (int k = 0; k < 8; k++) exp_q.push_back({(k == 7), sorted[k*8 +: 8]});
    endtask

    // Output monitor, sampling on the falling edge
    initial begin
        int         acc_cnt;
        bit         prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        logic [8:0] e;
        acc_cnt    = 0;
        prev_stall = 0;
        prev_data  = 8'h00;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc_cnt    = 0;
                prev_stall = 0;
            end else begin
                if (prev_stall && m_valid) begin
                    chk("stall_data", m_data, prev_data);
                    chk("stall_last", m_last, prev_last);
                end
                if (acc_cnt == 8) chk("s_ready_closed", s_ready, 1'b0);
                if (!flush && m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got %0h with nothing expected at %0t", m_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("m_data", m_data, e[7:0]);
                        chk("m_last", m_last, e[8]);
                    end
                    if (m_last) acc_cnt = 0;
                end
                if (!flush && s_valid && s_ready) acc_cnt++;
                if (flush) acc_cnt = 0;
                prev_stall = m_valid && !m_ready && !flush;
                prev_data  = m_data;
                prev_last  = m_last;
            end
        end
    end

    // m_ready driver: mode 0 always ready, mode 1 repeats 1,0,0
    int mr_mode = 0;
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mr_mode == 0) m_ready = 1'b1;
            else begin
                m_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end
        end
    end

    // Offer bytes of fr in slot order until cnt have been accepted
    task automatic drive_bytes(input logic [63:0] fr, input int cnt, input bit gaps);
        int k;
        int budget;
        k = 0;
        budget = 0;
        while (k < cnt && budget < 2000) begin
            s_data  = fr[k*8 +: 8];
            s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            if (s_valid && s_ready) k++;
            @(posedge clk);
            #1;
            budget++;
        end
        s_valid = 1'b0;
        chk("accept_count", k, cnt);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_complete", exp_q.size(), 0);
        chk("m_valid_idle", m_valid, 1'b0);
    endtask

    task automatic wait_q(input int sz);
        int n;
        n = 0;
        while (exp_q.size() != sz && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_drain_pos", exp_q.size(), sz);
    endtask

    typedef struct {
        logic [63:0] din;
        logic [63:0] exp;
        bit          gaps;
    } vec_t;

    vec_t tbl [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [63:0] f1;
        logic [63:0] f2;
        logic [63:0] srt;

        tbl[0] = '{mk(8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1),
                   mk(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8), 1'b0};
        tbl[1] = '{mk(8'hFF, 8'h00, 8'h7F, 8'h7F, 8'h80, 8'h00, 8'hFF, 8'h01),
                   mk(8'h00, 8'h00, 8'h01, 8'h7F, 8'h7F, 8'h80, 8'hFF, 8'hFF), 1'b0};
        tbl[2] = '{mk(8'd10, 8'd30, 8'd20, 8'd40, 8'd60, 8'd50, 8'd80, 8'd70),
                   mk(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80), 1'b1};
        tbl[3] = '{mk(8'h55, 8'h00, 8'h55, 8'hAA, 8'h00, 8'hAA, 8'h55, 8'h01),
                   mk(8'h00, 8'h00, 8'h01, 8'h55, 8'h55, 8'h55, 8'hAA, 8'hAA), 1'b1};

        // Reset held for three cycles
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_m_data", m_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sort_in", sort_in, 64'h0);
        @(posedge clk);
        #1;

        // Table-driven frames
        for (int i = 0; i < 4; i++) begin
            push_frame(tbl[i].exp);
            drive_bytes(tbl[i].din, 8, tbl[i].gaps);
            chk("sort_in_held", sort_in, tbl[i].din);
            chk("busy_in_wait", busy, 1'b1);
            chk("s_ready_in_wait", s_ready, 1'b0);
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!m_valid && lat < 20);
            chk("first_valid_latency", lat, 4);
            wait_drain();
        end

        // Two back-to-back random frames with input gaps and m_ready 1,0,0
        mr_mode = 1;
        f1 = {$urandom, $urandom};
        f2 = {$urandom, $urandom};
        push_frame(sort8(f1));
        drive_bytes(f1, 8, 1'b1);
        push_frame(sort8(f2));
        drive_bytes(f2, 8, 1'b1);
        wait_drain();
        mr_mode = 0;
        @(posedge clk);
        #1;

        // Flush after five accepts, with a simultaneous offered byte
        drive_bytes(mk(8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7), 5, 1'b0);
        chk("busy_partial", busy, 1'b1);
        flush   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hEE;
        @(posedge clk);
        #1;
        flush   = 1'b0;
        s_valid = 1'b0;
        chk("flush_fill_busy", busy, 1'b0);
        chk("flush_fill_s_ready", s_ready, 1'b1);
        push_frame(tbl[2].exp);
        drive_bytes(tbl[2].din, 8, 1'b0);
        wait_drain();

        // Flush while draining at index 3
        f1  = {$urandom, $urandom};
        srt = sort8(f1);
        push_frame(srt);
        drive_bytes(f1, 8, 1'b0);
        wait_q(5);
        chk("drain_idx3_data", m_data, srt[3*8 +: 8]);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        exp_q.delete();
        chk("flush_drain_m_valid", m_valid, 1'b0);
        chk("flush_drain_busy", busy, 1'b0);
        chk("flush_drain_s_ready", s_ready, 1'b1);
        push_frame(tbl[0].exp);
        drive_bytes(tbl[0].din, 8, 1'b0);
        wait_drain();

        // Asynchronous reset while draining at index 4
        f1  = {$urandom, $urandom};
        srt = sort8(f1);
        push_frame(srt);
        drive_bytes(f1, 8, 1'b0);
        wait_q(4);
        chk("drain_idx4_data", m_data, srt[4*8 +: 8]);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_m_valid", m_valid, 1'b0);
        chk("async_rst_m_last", m_last, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_frame(tbl[1].exp);
        drive_bytes(tbl[1].din, 8, 1'b0);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
